sargantana_icache_line_fill: RTL and testbench

Refill line-fill buffer upstream of the instruction-cache data memory. Accepts a refill request (set index plus one-hot victim way) and collects `SET_WIDHT/BEAT_WIDTH` memory-response beats into a full cache line. It then issues a single-cycle write into the data memory, driving its per-way `req`, `we`, `data` and `addr` inputs. Error beats or a flush discard the line without writing.

---
 rtl/sargantana_icache_line_fill.sv | 133 +++++++++++++
 tb/tb_sargantana_icache_line_fill.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_icache_line_fill.sv
// Line-fill buffer: gathers SET_WIDHT/BEAT_WIDTH response beats into one line, then writes it to the way-selected data memory (ICACHE_FILL_BYPASS_EN adds a fetch bypass port).
// Latency: the write cycle follows the last beat by one cycle; an error discard pulses fill_err_o at the same point.
// Backpressure: fill_ready_o only in IDLE without flush; beats have no backpressure and are dropped outside COLLECT.
module sargantana_icache_line_fill #(
    parameter int ICACHE_N_WAY = 4,
    parameter int SET_WIDHT    = 256,
    parameter int ADDR_WIDHT   = 6,
    parameter int BEAT_WIDTH   = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    fill_valid_i,
    output logic                    fill_ready_o,
    input  logic [ADDR_WIDHT-1:0]   fill_idx_i,
    input  logic [ICACHE_N_WAY-1:0] fill_way_i,
    input  logic                    beat_valid_i,
    input  logic [BEAT_WIDTH-1:0]   beat_data_i,
    input  logic                    beat_err_i,
    input  logic                    flush_i,
    output logic [ICACHE_N_WAY-1:0] mem_req_o,
    output logic                    mem_we_o,
    output logic [SET_WIDHT-1:0]    mem_data_o,
    output logic [ADDR_WIDHT-1:0]   mem_addr_o,
    output logic                    fill_done_o,
    output logic                    fill_err_o,
    output logic                    busy_o
`ifdef ICACHE_FILL_BYPASS_EN
    ,
    output logic                    bypass_valid_o,
    output logic [SET_WIDHT-1:0]    bypass_data_o
`endif
);

    localparam int N_BEATS = SET_WIDHT / BEAT_WIDTH;
    localparam int CNT_W   = $clog2(N_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDHT-1:0]   idx_q, addr_q;
    logic [ICACHE_N_WAY-1:0] way_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    err_flag_q, fill_err_q;
    logic [SET_WIDHT-1:0]    line_q, line_d, data_q;
    logic                    accept, beat_take, last_beat, line_bad, write_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        beat_take = 1'b0;
        last_beat = 1'b0;
        line_bad  = 1'b0;
        line_d    = line_q;
        line_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = beat_data_i;
        case (state_q)
            IDLE: begin
                if (fill_valid_i) begin
                    accept  = 1'b1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (beat_valid_i) begin
                    beat_take = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        last_beat = 1'b1;
                        line_bad  = err_flag_q | beat_err_i;
                        state_d   = line_bad ? IDLE : WRITE;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            accept  = 1'b0;
        end
        // Write-side strobes are gated combinationally so a same-cycle flush or reset kills them.
        write_ok     = (state_q == WRITE) && !flush_i && !rst_i;
        fill_ready_o = (state_q == IDLE) && !flush_i && !rst_i;
        busy_o       = (state_q != IDLE) && !rst_i;
        mem_req_o    = write_ok ? way_q : '0;
        mem_we_o     = write_ok;
        fill_done_o  = write_ok;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q      <= '0;
            way_q      <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            fill_err_q <= 1'b0;
            line_q     <= '0;
            data_q     <= '0;
            addr_q     <= '0;
        end else begin
            fill_err_q <= last_beat && line_bad && !flush_i;
            if (accept) begin
                idx_q      <= fill_idx_i;
                way_q      <= fill_way_i;
                cnt_q      <= '0;
                err_flag_q <= 1'b0;
            end else if (beat_take) begin
                line_q     <= line_d;
                cnt_q      <= cnt_q + CNT_W'(1);
                err_flag_q <= err_flag_q | beat_err_i;
            end
            // Separate output copy so the next fill's beats do not disturb the held write data.
            if (last_beat && !line_bad && !flush_i) begin
                data_q <= line_d;
                addr_q <= idx_q;
            end
        end
    end

    assign mem_data_o = data_q;
    assign mem_addr_o = addr_q;
    assign fill_err_o = fill_err_q && !rst_i;

`ifdef ICACHE_FILL_BYPASS_EN
    assign bypass_valid_o = write_ok;
    assign bypass_data_o  = data_q;
`endif

endmodule

// File: tb/tb_sargantana_icache_line_fill.sv
// Bench for sargantana_icache_line_fill: scripted and random fills against a line-level reference model.
module tb_sargantana_icache_line_fill;
    localparam int NW = 4;
    localparam int SW = 256;
    localparam int AW = 6;
    localparam int BW = 64;
    localparam int NB = SW / BW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          fill_valid_i = 1'b0;
    logic          fill_ready_o;
    logic [AW-1:0] fill_idx_i = '0;
    logic [NW-1:0] fill_way_i = '0;
    logic          beat_valid_i = 1'b0;
    logic [BW-1:0] beat_data_i = '0;
    logic          beat_err_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [NW-1:0] mem_req_o;
    logic          mem_we_o;
    logic [SW-1:0] mem_data_o;
    logic [AW-1:0] mem_addr_o;
    logic          fill_done_o;
    logic          fill_err_o;
    logic          busy_o;
    logic          obs_byp;
    logic [SW-1:0] data_byp;

    int nvec = 0;
    int nerr = 0;
    logic [SW-1:0] last_line = '0;
    logic [AW-1:0] last_addr = '0;

    always #5 clk_i = ~clk_i;

`ifdef ICACHE_FILL_BYPASS_EN
    logic          bypass_valid_o;
    logic [SW-1:0] bypass_data_o;
    assign obs_byp  = bypass_valid_o;
    assign data_byp = bypass_data_o;
`else
    assign obs_byp  = fill_done_o;
    assign data_byp = mem_data_o;
`endif

    wire [9:0] obs = {fill_ready_o, busy_o, mem_req_o, mem_we_o, fill_done_o, fill_err_o, obs_byp};

    sargantana_icache_line_fill #(
        .ICACHE_N_WAY(NW), .SET_WIDHT(SW), .ADDR_WIDHT(AW), .BEAT_WIDTH(BW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o),
        .fill_idx_i(fill_idx_i), .fill_way_i(fill_way_i),
        .beat_valid_i(beat_valid_i), .beat_data_i(beat_data_i), .beat_err_i(beat_err_i),
        .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
        .fill_done_o(fill_done_o), .fill_err_o(fill_err_o), .busy_o(busy_o)
`ifdef ICACHE_FILL_BYPASS_EN
        , .bypass_valid_o(bypass_valid_o), .bypass_data_o(bypass_data_o)
`endif
    );

    function automatic logic [BW-1:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [SW-1:0] rnd_line();
        logic [SW-1:0] l;
        for (int i = 0; i < SW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic drive(input logic fv, input logic [AW-1:0] ix, input logic [NW-1:0] w,
                         input logic bv, input logic [BW-1:0] bd, input logic be, input logic fl);
        fill_valid_i = fv;
        fill_idx_i   = ix;
        fill_way_i   = w;
        beat_valid_i = bv;
        beat_data_i  = bd;
        beat_err_i   = be;
        flush_i      = fl;
    endtask

    // One fill: accept, beats with gaps (gap<0 means random), optional flush on beat flush_beat or in the write cycle.
    task automatic do_fill(input string name, input logic [AW-1:0] idx, input logic [NW-1:0] way,
                           input logic [SW-1:0] line, input int gap, input logic [NB-1:0] err_mask,
                           input int flush_beat, input bit flush_wr);
        logic [9:0] e;
        bit bad;
        int g;
        bad = 1'b0;
        // Acceptance cycle carries a junk error beat that must be ignored.
        @(negedge clk_i);
        drive(1'b1, idx, way, 1'b1, r64(), 1'b1, 1'b0);
        #4;
        e = {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        nvec++;
        if (obs !== e) begin nerr++; $display("FAIL %s accept: obs=%b exp=%b", name, obs, e); end
        nvec++;
        if ({mem_addr_o, mem_data_o, data_byp} !== {last_addr, last_line, last_line}) begin
            nerr++;
            $display("FAIL %s hold: addr=%h data=%h exp_addr=%h exp_data=%h", name, mem_addr_o, mem_data_o, last_addr, last_line);
        end
        for (int k = 0; k < NB; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int j = 0; j < g; j++) begin
                @(negedge clk_i);
                drive(1'($urandom), AW'($urandom), NW'($urandom), 1'b0, r64(), 1'($urandom), 1'b0);
                #4;
                e = {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
                nvec++;
                if (obs !== e) begin nerr++; $display("FAIL %s gap%0d: obs=%b exp=%b", name, k, obs, e); end
            end
            @(negedge clk_i);
            drive(1'($urandom), AW'($urandom), NW'($urandom), 1'b1, line[k*BW +: BW], err_mask[k], k == flush_beat);
            bad = bad | err_mask[k];
            #4;
            e = {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
            nvec++;
            if (obs !== e) begin nerr++; $display("FAIL %s beat%0d: obs=%b exp=%b", name, k, obs, e); end
            if (k == flush_beat) begin
                @(negedge clk_i);
                drive(1'b0, '0, '0, 1'b0, r64(), 1'b0, 1'b0);
                #4;
                e = {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
                nvec++;
                if (obs !== e) begin nerr++; $display("FAIL %s after_flush: obs=%b exp=%b", name, obs, e); end
                return;
            end
        end
        @(negedge clk_i);
        drive(1'b0, '0, '0, 1'b0, r64(), 1'b0, flush_wr);
        #4;
        if (bad) begin
            e = {~flush_wr, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        end else begin
            e = {1'b0, 1'b1, flush_wr ? 4'b0000 : way, ~flush_wr, ~flush_wr, 1'b0, ~flush_wr};
            last_line = line;
            last_addr = idx;
        end
        nvec++;
        if (obs !== e) begin nerr++; $display("FAIL %s result: obs=%b exp=%b", name, obs, e); end
        nvec++;
        if ({mem_addr_o, mem_data_o, data_byp} !== {last_addr, last_line, last_line}) begin
            nerr++;
            $display("FAIL %s line: addr=%h data=%h exp_addr=%h exp_data=%h", name, mem_addr_o, mem_data_o, last_addr, last_line);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk_i);
        #4;
        nvec++;
        if ({obs, mem_addr_o, mem_data_o} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: obs=%b addr=%h data=%h exp all zero", obs, mem_addr_o, mem_data_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        #4;
        nvec++;
        if (obs !== 10'b1000000000) begin nerr++; $display("FAIL reset_ready: obs=%b exp=%b", obs, 10'b1000000000); end
        last_line = '0;
        last_addr = '0;
    endtask

    task automatic test_normal();
        logic [SW-1:0] l;
        l = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        do_fill("normal", 6'h2A, 4'b0100, l, 0, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_gapped();
        logic [SW-1:0] l;
        l = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        do_fill("gapped", 6'h2A, 4'b0100, l, 3, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_error();
        do_fill("error", 6'h11, 4'b0010, rnd_line(), 1, 4'b0010, -1, 1'b0);
        do_fill("error_last", 6'h12, 4'b0001, rnd_line(), 0, 4'b1000, -1, 1'b0);
    endtask

    task automatic test_flush_mid();
        do_fill("flush_mid", 6'h33, 4'b1000, rnd_line(), 0, 4'b0000, 2, 1'b0);
        do_fill("refill_05", 6'h05, 4'b0001, rnd_line(), 0, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_flush_write();
        do_fill("flush_write", 6'h3F, 4'b0100, rnd_line(), 0, 4'b0000, -1, 1'b1);
        do_fill("flush_last_err", 6'h07, 4'b0010, rnd_line(), 0, 4'b0001, 3, 1'b0);
    endtask

    task automatic test_flush_idle();
        @(negedge clk_i);
        drive(1'b1, 6'h15, 4'b0001, 1'b0, '0, 1'b0, 1'b1);
        #4;
        nvec++;
        if (obs !== 10'b0000000000) begin nerr++; $display("FAIL flush_idle: obs=%b exp=%b", obs, 10'b0); end
        @(negedge clk_i);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        #4;
        nvec++;
        if (obs !== 10'b1000000000) begin nerr++; $display("FAIL flush_idle_next: obs=%b exp=%b", obs, 10'b1000000000); end
    endtask

    task automatic test_odd_way();
        do_fill("way_zero", 6'h01, 4'b0000, rnd_line(), 0, 4'b0000, -1, 1'b0);
        do_fill("way_multi", 6'h02, 4'b1011, rnd_line(), -1, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        drive(1'b1, 6'h29, 4'b0100, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        drive(1'b0, '0, '0, 1'b1, r64(), 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            rst_i = 1'b1;
            drive(1'b1, AW'($urandom), NW'($urandom), 1'b1, r64(), 1'b1, 1'b0);
            #4;
            nvec++;
            if (obs !== 10'b0) begin nerr++; $display("FAIL reset_mid%0d: obs=%b exp=%b", c, obs, 10'b0); end
        end
        nvec++;
        if ({mem_addr_o, mem_data_o, data_byp} !== '0) begin
            nerr++;
            $display("FAIL reset_mid_data: addr=%h data=%h exp zero", mem_addr_o, mem_data_o);
        end
        last_line = '0;
        last_addr = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            rst_i = 1'b0;
            drive(1'b0, '0, '0, 1'b1, r64(), 1'($urandom), 1'b0);
            #4;
            nvec++;
            if (obs !== 10'b1000000000) begin nerr++; $display("FAIL stray_beat%0d: obs=%b exp=%b", c, obs, 10'b1000000000); end
        end
        do_fill("after_reset", 6'h0C, 4'b0010, rnd_line(), -1, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [NB-1:0] em;
        int fb;
        for (int n = 0; n < 40; n++) begin
            em = ($urandom_range(0, 3) == 0) ? NB'(1 << $urandom_range(0, NB - 1)) : '0;
            fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            do_fill("random", AW'($urandom), NW'($urandom), rnd_line(), -1, em, fb, $urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_gapped();
        test_error();
        test_flush_mid();
        test_flush_write();
        test_flush_idle();
        test_odd_way();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
